// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between ex_mem and mem_wb.
//
// ALU results pass straight through. Loads and stores are serialised one byte
// per cycle over the shared 8-bit external RAM port (little-endian, byte i at
// base+i, address wraps modulo 2^ADDR_W). While an access is in flight the
// stage raises stall_req_o. Load data is sign/zero-extended before write-back.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   mem_op_i            0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH,
//                       8 SW, 9-15 none
//   mem_addr_i          byte address, mem_sdata_i store data
//   wd_i/wreg_i/wdata_i destination, write enable, ALU result
//   mem_grant_i         RAM port grant from the fetch/memory arbiter
//   mem_req_o           RAM port request
//   mem_a_o/mem_dout_o/mem_wr_o  registered RAM address, write byte, write
//   mem_din_i           read byte, valid one cycle after its address
//   wb_stall_i          downstream stall, holds a completed result in DONE
//   stall_req_o         stall request to the pipeline controller
//   wb_wd_o/wb_wreg_o/wb_wdata_o  outputs to mem_wb
//   dbg_state_o         current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Optional build macro: MEM_TRACE_EN prints one line per completed access.
//
// Handshake: mem_req_o/mem_grant_i behave as valid/ready. The request is held
// from the first IDLE cycle with a memory op; the grant is sampled only in
// IDLE, and once taken the arbiter keeps the port for the whole access, so
// the BUSY phase never looks at mem_grant_i again.
module mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        mem_op_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_sdata_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic              mem_grant_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic [7:0]        mem_dout_o,
    output logic              mem_wr_o,
    input  logic [7:0]        mem_din_i,
    input  logic              wb_stall_i,
    output logic              stall_req_o,
    output logic [4:0]        wb_wd_o,
    output logic              wb_wreg_o,
    output logic [31:0]       wb_wdata_o,
    output logic [1:0]        dbg_state_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Number of bytes moved by an op; 0 means "not a memory op".
    function automatic logic [2:0] op_len(input logic [3:0] op);
        case (op)
            4'd1, 4'd4, 4'd6: op_len = 3'd1;
            4'd2, 4'd5, 4'd7: op_len = 3'd2;
            4'd3, 4'd8:       op_len = 3'd4;
            default:          op_len = 3'd0;
        endcase
    endfunction

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       ldbuf_q, ldbuf_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [7:0]        dout_q, dout_d;
    logic              wr_q, wr_d;

    logic              in_mem;
    logic [2:0]        len_q;
    logic              store_q;
    logic [2:0]        lane;
    logic [7:0]        sbyte;
    logic [31:0]       load_ext;
    logic [31:0]       wb_wdata_raw;

    assign in_mem  = (op_len(mem_op_i) != 3'd0);
    // The op is captured at grant so DONE does not depend on ex_mem holding.
    assign len_q   = op_len(op_q);
    assign store_q = (op_q >= 4'd6) && (op_q <= 4'd8);

    always_comb begin
        sbyte = mem_sdata_i[7:0];
        case (cnt_q[1:0])
            2'd0: sbyte = mem_sdata_i[7:0];
            2'd1: sbyte = mem_sdata_i[15:8];
            2'd2: sbyte = mem_sdata_i[23:16];
            2'd3: sbyte = mem_sdata_i[31:24];
            default: sbyte = mem_sdata_i[7:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        ldbuf_d = ldbuf_q;
        op_d    = op_q;
        a_d     = a_q;
        dout_d  = dout_q;
        wr_d    = wr_q;
        // cnt runs one ahead of the collected byte: the data for the byte
        // driven while cnt was c arrives while cnt is c+1, i.e. lane cnt-2.
        lane    = cnt_q - 3'd2;
        case (state_q)
            IDLE: begin
                if (in_mem && mem_grant_i) begin
                    state_d = BUSY;
                    base_d  = mem_addr_i;
                    op_d    = mem_op_i;
                    a_d     = mem_addr_i;
                    wr_d    = (mem_op_i >= 4'd6);
                    dout_d  = mem_sdata_i[7:0];
                    cnt_d   = 3'd1;
                    ldbuf_d = 32'd0;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q < len_q) begin
                    a_d    = base_q + ADDR_W'(cnt_q);
                    dout_d = sbyte;
                end
                if (!store_q && (cnt_q >= 3'd2)) begin
                    for (int k = 0; k < 4; k++) begin
                        if (lane == 3'(k)) ldbuf_d[8*k +: 8] = mem_din_i;
                    end
                end
                // Stores finish after issuing byte N-1; loads need one more
                // cycle to collect its read data.
                if (store_q ? (cnt_q == len_q) : (cnt_q == len_q + 3'd1)) begin
                    state_d = DONE;
                    wr_d    = 1'b0;
                end
            end
            DONE: begin
                if (!wb_stall_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_ext = ldbuf_q;
        case (op_q)
            4'd1: load_ext = {{24{ldbuf_q[7]}}, ldbuf_q[7:0]};
            4'd2: load_ext = {{16{ldbuf_q[15]}}, ldbuf_q[15:0]};
            4'd4: load_ext = {24'd0, ldbuf_q[7:0]};
            4'd5: load_ext = {16'd0, ldbuf_q[15:0]};
            default: load_ext = ldbuf_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            base_q  <= '0;
            ldbuf_q <= 32'd0;
            op_q    <= 4'd0;
            a_q     <= '0;
            dout_q  <= 8'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            ldbuf_q <= ldbuf_d;
            op_q    <= op_d;
            a_q     <= a_d;
            dout_q  <= dout_d;
            wr_q    <= wr_d;
        end
    end

    assign wb_wdata_raw = ((state_q == DONE) && !store_q) ? load_ext : wdata_i;

    // Combinational outputs are forced low while reset is held.
    assign mem_a_o     = a_q;
    assign mem_dout_o  = dout_q;
    assign mem_wr_o    = wr_q;
    assign stall_req_o = rst & (((state_q == IDLE) && in_mem) || (state_q == BUSY));
    assign mem_req_o   = rst & (((state_q == IDLE) && in_mem) ||
                                ((state_q == BUSY) && (cnt_q <= len_q)));
    assign wb_wd_o     = rst ? wd_i : 5'd0;
    assign wb_wreg_o   = rst & wreg_i;
    assign wb_wdata_o  = rst ? wb_wdata_raw : 32'd0;
    assign dbg_state_o = state_q;

`ifdef MEM_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst && (state_q == DONE) && !wb_stall_i) begin
            if (store_q) $display("mem %h %h", base_q, mem_sdata_i);
            else         $display("mem %h %h", base_q, wb_wdata_o);
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: reset values, pass-through, a table of
// directed accesses, a reset-abort sequence and randomized accesses checked
// against a byte-array memory model.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  mem_op_i = 4'd0;
  logic [31:0] mem_addr_i = 32'd0;
  logic [31:0] mem_sdata_i = 32'd0;
  logic [4:0]  wd_i = 5'd0;
  logic        wreg_i = 1'b0;
  logic [31:0] wdata_i = 32'd0;
  logic        mem_grant_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_a_o;
  logic [7:0]  mem_dout_o;
  logic        mem_wr_o;
  logic [7:0]  mem_din_i = 8'd0;
  logic        wb_stall_i = 1'b0;
  logic        stall_req_o;
  logic [4:0]  wb_wd_o;
  logic        wb_wreg_o;
  logic [31:0] wb_wdata_o;
  logic [1:0]  dbg_state_o;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd2;

  mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
    .mem_sdata_i(mem_sdata_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .mem_grant_i(mem_grant_i), .mem_req_o(mem_req_o), .mem_a_o(mem_a_o),
    .mem_dout_o(mem_dout_o), .mem_wr_o(mem_wr_o), .mem_din_i(mem_din_i),
    .wb_stall_i(wb_stall_i), .stall_req_o(stall_req_o), .wb_wd_o(wb_wd_o),
    .wb_wreg_o(wb_wreg_o), .wb_wdata_o(wb_wdata_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // RAM seen by the DUT, and the bench's own reference copy
  logic [7:0] ram [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  // External RAM: write at the edge ending a write cycle, return read data
  // for the address of the cycle that just ended.
  always @(posedge clk) begin
    logic [31:0] ra;
    logic        rw;
    logic [7:0]  rd;
    ra = mem_a_o;
    rw = mem_wr_o;
    rd = mem_dout_o;
    #1;
    if (rw) ram[ra] = rd;
    mem_din_i = ram.exists(ra) ? ram[ra] : 8'h00;
  end

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic int op_bytes(input int op);
    case (op)
      1, 4, 6: return 1;
      2, 5, 7: return 2;
      3, 8:    return 4;
      default: return 0;
    endcase
  endfunction

  // Load result from the reference memory using plain arithmetic.
  function automatic logic [31:0] model_load(input int op, input logic [31:0] addr);
    longint v;
    logic [31:0] a;
    int n;
    v = 0;
    n = op_bytes(op);
    for (int i = 0; i < n; i++) begin
      a = addr + i;
      v += longint'(ref_rd(a)) << (8 * i);
    end
    if (op == 1 && v >= 128) v -= 256;
    if (op == 2 && v >= 32768) v -= 65536;
    return v[31:0];
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    ram[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // driver: one full access, with wt grant-low cycles and hold DONE-stall cycles
  task automatic run_access(input string tag, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [31:0] wdata,
                            input int wt, input int hold,
                            input logic [31:0] exp_data, input int exp_stall);
    int n;
    bit st;
    int stalls;
    bit done;
    logic [31:0] a0;
    logic [31:0] ea;
    n = op_bytes(int'(op));
    st = (op >= 4'd6);
    stalls = 0;
    done = 1'b0;
    a0 = 32'd0;
    @(negedge clk);
    mem_op_i = op; mem_addr_i = addr; mem_sdata_i = sdata;
    wd_i = 5'd7; wreg_i = 1'b1; wdata_i = wdata; wb_stall_i = (hold > 0);
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      mem_grant_i = (cyc >= wt);
      #1;
      if (cyc == 0) a0 = mem_a_o;
      if (stall_req_o) begin
        stalls++;
        if (cyc <= wt) begin
          check({tag, "_req"}, 32'(mem_req_o), 32'd1);
          check({tag, "_wait_wr"}, 32'(mem_wr_o), 32'd0);
          check({tag, "_wait_a"}, mem_a_o, a0);
        end else if (cyc <= wt + n) begin
          ea = addr + (cyc - wt - 1);
          check({tag, "_addr"}, mem_a_o, ea);
          check({tag, "_wr"}, 32'(mem_wr_o), 32'(st));
        end
      end else begin
        done = 1'b1;
        check({tag, "_data"}, wb_wdata_o, exp_data);
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
        check({tag, "_wd"}, 32'(wb_wd_o), 32'd7);
        check({tag, "_done_wr"}, 32'(mem_wr_o), 32'd0);
        check({tag, "_state_done"}, 32'(dbg_state_o), 32'(S_DONE));
      end
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: got no completion required completion in 60 cycles", tag);
    end
    for (int j = 1; j <= hold; j++) begin
      @(negedge clk);
      if (j == hold) wb_stall_i = 1'b0;
      #1;
      check({tag, "_hold_data"}, wb_wdata_o, exp_data);
      check({tag, "_hold_stall"}, 32'(stall_req_o), 32'd0);
      check({tag, "_hold_state"}, 32'(dbg_state_o), 32'(S_DONE));
    end
    @(negedge clk);
    mem_op_i = 4'd0; mem_grant_i = 1'b0; wb_stall_i = 1'b0;
    #1;
    check({tag, "_back_idle"}, 32'(dbg_state_o), 32'(S_IDLE));
    if (st) begin
      for (int i = 0; i < n; i++) begin
        ea = addr + i;
        ref_mem[ea] = sdata[8*i +: 8];
        check({tag, "_ram"}, 32'(ram_rd(ea)), 32'(ref_rd(ea)));
      end
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] wdata;
    bit          poke_en;
    logic [31:0] bytes;
    int          wt;
    int          hold;
    logic [31:0] exp_data;
    int          exp_stall;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [3:0]  rop;
    logic [31:0] raddr, rsd, rwd, rexp;
    int          rwt, rhold, rn;

    vecs[0]  = '{4'd3, 32'h0000_0100, 32'h0, 32'h0, 1'b1, 32'h4433_2211, 0, 0, 32'h4433_2211, 6};
    vecs[1]  = '{4'd1, 32'h0000_0203, 32'h0, 32'h0, 1'b1, 32'h0000_0080, 0, 0, 32'hFFFF_FF80, 3};
    vecs[2]  = '{4'd4, 32'h0000_0203, 32'h0, 32'h0, 1'b0, 32'h0,         0, 0, 32'h0000_0080, 3};
    vecs[3]  = '{4'd7, 32'h0000_0010, 32'hABCD_1234, 32'h0000_AAAA, 1'b0, 32'h0, 0, 0, 32'h0000_AAAA, 3};
    vecs[4]  = '{4'd3, 32'h0000_0100, 32'h0, 32'h0, 1'b0, 32'h0,         3, 0, 32'h4433_2211, 9};
    vecs[5]  = '{4'd2, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 32'h0000_8001, 0, 0, 32'hFFFF_8001, 4};
    vecs[6]  = '{4'd5, 32'h0000_0005, 32'h0, 32'h0, 1'b1, 32'h0000_F00F, 0, 0, 32'h0000_F00F, 4};
    vecs[7]  = '{4'd8, 32'h0000_0300, 32'h1234_5678, 32'h1111_0000, 1'b0, 32'h0, 0, 0, 32'h1111_0000, 5};
    vecs[8]  = '{4'd3, 32'h0000_0300, 32'h0, 32'h0, 1'b0, 32'h0,         0, 0, 32'h1234_5678, 6};
    vecs[9]  = '{4'd1, 32'h0000_0301, 32'h0, 32'h0, 1'b0, 32'h0,         0, 2, 32'h0000_0056, 3};
    vecs[10] = '{4'd2, 32'h0000_0101, 32'h0, 32'h0, 1'b0, 32'h0,         0, 0, 32'h0000_3322, 4};
    vecs[11] = '{4'd6, 32'h0000_0400, 32'hFFFF_FFEE, 32'h0BAD_F00D, 1'b0, 32'h0, 1, 0, 32'h0BAD_F00D, 3};
    vecs[12] = '{4'd1, 32'h0000_0400, 32'h0, 32'h0, 1'b0, 32'h0,         0, 1, 32'hFFFF_FFEE, 3};
    vecs[13] = '{4'd5, 32'h0000_0010, 32'h0, 32'h0, 1'b0, 32'h0,         0, 0, 32'h0000_1234, 4};

    // reset: every output low while rst is held, even with an op present
    mem_op_i = 4'd3; mem_addr_i = 32'h1234_5678; wd_i = 5'd9; wreg_i = 1'b1;
    wdata_i = 32'hDEAD_BEEF; mem_grant_i = 1'b1;
    #2;
    check("rst_stall", 32'(stall_req_o), 32'd0);
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_wr", 32'(mem_wr_o), 32'd0);
    check("rst_a", mem_a_o, 32'd0);
    check("rst_dout", 32'(mem_dout_o), 32'd0);
    check("rst_wb_wdata", wb_wdata_o, 32'd0);
    check("rst_wb_wd", 32'(wb_wd_o), 32'd0);
    check("rst_wb_wreg", 32'(wb_wreg_o), 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'(S_IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_op_i = 4'd0; mem_grant_i = 1'b0; rst = 1'b1;

    // pass-through: zero latency, never stalls
    @(negedge clk);
    mem_op_i = 4'd0; wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'd5;
    #1;
    check("nop_wdata", wb_wdata_o, 32'd5);
    check("nop_wd", 32'(wb_wd_o), 32'd3);
    check("nop_wreg", 32'(wb_wreg_o), 32'd1);
    check("nop_stall", 32'(stall_req_o), 32'd0);
    check("nop_req", 32'(mem_req_o), 32'd0);
    wdata_i = 32'hCAFE_0001; wreg_i = 1'b0; mem_op_i = 4'd9;
    #1;
    check("op9_wdata", wb_wdata_o, 32'hCAFE_0001);
    check("op9_wreg", 32'(wb_wreg_o), 32'd0);
    check("op9_stall", 32'(stall_req_o), 32'd0);
    mem_op_i = 4'd15; mem_grant_i = 1'b1;
    @(negedge clk);
    #1;
    check("op15_state", 32'(dbg_state_o), 32'(S_IDLE));
    check("op15_req", 32'(mem_req_o), 32'd0);
    mem_op_i = 4'd0; mem_grant_i = 1'b0;

    // directed table
    for (int v = 0; v < 14; v++) begin
      if (vecs[v].poke_en) begin
        for (int i = 0; i < 4; i++) poke(vecs[v].addr + i, vecs[v].bytes[8*i +: 8]);
      end
      run_access($sformatf("vec%0d", v), vecs[v].op, vecs[v].addr, vecs[v].sdata,
                 vecs[v].wdata, vecs[v].wt, vecs[v].hold, vecs[v].exp_data, vecs[v].exp_stall);
    end

    // reset in the middle of an SW: byte 0 stays written, byte 1 never lands
    poke(32'h41, 8'h5E);
    @(negedge clk);
    mem_op_i = 4'd8; mem_addr_i = 32'h40; mem_sdata_i = 32'hDDCC_BBAA; mem_grant_i = 1'b1;
    @(negedge clk);
    #1;
    check("abort_t1_a", mem_a_o, 32'h40);
    check("abort_t1_wr", 32'(mem_wr_o), 32'd1);
    @(negedge clk);
    #1;
    check("abort_t2_a", mem_a_o, 32'h41);
    rst = 1'b0;
    #1;
    check("abort_wr_async", 32'(mem_wr_o), 32'd0);
    check("abort_stall", 32'(stall_req_o), 32'd0);
    check("abort_a", mem_a_o, 32'd0);
    @(negedge clk);
    mem_op_i = 4'd0; mem_grant_i = 1'b0; rst = 1'b1;
    ref_mem[32'h40] = 8'hAA;
    #1;
    check("abort_state_idle", 32'(dbg_state_o), 32'(S_IDLE));
    check("abort_byte0", 32'(ram_rd(32'h40)), 32'(ref_rd(32'h40)));
    check("abort_byte1", 32'(ram_rd(32'h41)), 32'(ref_rd(32'h41)));

    // randomized accesses against the reference memory
    for (int r = 0; r < 40; r++) begin
      rop = 4'($urandom_range(1, 8));
      if ($urandom_range(0, 1) == 1) raddr = 32'hFFFF_FFFC + $urandom_range(0, 3);
      else raddr = 32'h0000_1000 + $urandom_range(0, 12);
      rsd = $urandom;
      rwd = $urandom;
      rwt = int'($urandom_range(0, 2));
      rhold = int'($urandom_range(0, 1));
      rn = op_bytes(int'(rop));
      if (rop <= 4'd5 && $urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 4; i++) poke(raddr + i, 8'($urandom));
      end
      rexp = (rop >= 4'd6) ? rwd : model_load(int'(rop), raddr);
      run_access($sformatf("rnd%0d", r), rop, raddr, rsd, rwd, rwt, rhold, rexp,
                 rwt + rn + ((rop >= 4'd6) ? 1 : 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline. It sits between the `ex_mem` latch and the `mem_wb` latch. ALU results pass straight through, while loads and stores are serialised over the shared 8-bit external RAM port. While an access is in flight the stage raises a stall request to the pipeline controller. It also sign- or zero-extends load data before handing the result to write-back.

## Interface
Parameters:
- `ADDR_W`, 32, memory address width (must equal `InstAddrBus` width).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: rising-edge clock.
  - `rst` in 1: asynchronous, active-low reset (low = reset).
- Inputs from `ex_mem` (held stable by `ex_mem` while `stall_req_o`=1):
  - `mem_op_i` in 4: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9–15 are treated as none.
  - `mem_addr_i` in 32: byte address of the access.
  - `mem_sdata_i` in 32: store data.
  - `wd_i` in 5, `wreg_i` in 1, `wdata_i` in 32: destination register, write enable and ALU result.
- Arbitration and external RAM port:
  - `mem_grant_i` in 1: RAM port granted by the instruction-fetch/memory arbiter.
  - `mem_req_o` out 1: RAM port requested.
  - `mem_a_o` out 32: RAM byte address (registered).
  - `mem_dout_o` out 8: RAM write byte (registered).
  - `mem_wr_o` out 1: 1 = write, 0 = read (registered).
  - `mem_din_i` in 8: read byte, valid one cycle after its address is driven.
- Pipeline control and write-back:
  - `wb_stall_i` in 1: downstream stall; holds the completed result.
  - `stall_req_o` out 1: stall request to the controller.
  - `wb_wd_o` out 5, `wb_wreg_o` out 1, `wb_wdata_o` out 32: outputs to `mem_wb`.

## Operation
- State machine has three states: IDLE, BUSY, DONE. Internal registers: byte counter `cnt` (3 bits), captured `base` address, 32-bit `ldbuf`.
- N = 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW.
- Byte order is little-endian: byte i lives at address `base + i`. The 32-bit addition wraps modulo 2^32 (0xFFFFFFFF + 1 = 0x00000000).
- No alignment check; misaligned halfwords and words are accessed byte by byte.
- **IDLE, memory op 0:**
  - `wb_*` are combinational copies of `wd_i`/`wreg_i`/`wdata_i`.
  - `stall_req_o`=0, `mem_req_o`=0.
- **IDLE, memory op 1–8:**
  - `stall_req_o`=1 and `mem_req_o`=1.
  - If `mem_grant_i`=0: stay in IDLE.
  - If `mem_grant_i`=1: at the clock edge, register `mem_a_o`=addr, `mem_wr_o`=store, `mem_dout_o`=sdata[7:0]; set `cnt`=1; go to BUSY.
- **BUSY:**
  - While `cnt` < N, each edge drives byte `cnt` (address `base+cnt`, sdata[8*cnt+7:8*cnt]) and increments `cnt`.
  - Loads: each edge also latches `mem_din_i` into `ldbuf` byte lane k, for the byte whose address was driven in the previous cycle.
  - When the last byte has been issued (stores) or collected (loads), force `mem_wr_o`=0 and go to DONE.
  - `mem_req_o`=1 until the final issue cycle. `mem_grant_i` is sampled only in IDLE; the arbiter never revokes a grant mid-access.
- **DONE:**
  - `stall_req_o`=0.
  - `wb_wdata_o` = extended `ldbuf` for loads, `wdata_i` for stores. `wb_wd_o`/`wb_wreg_o` come from the inputs.
  - Extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - Stay in DONE while `wb_stall_i`=1; otherwise go to IDLE on the next edge.
- **Reset** (asynchronous, any state):
  - State → IDLE; `cnt`, `base`, `ldbuf`, `mem_a_o`, `mem_dout_o` → 0; `mem_wr_o` → 0 immediately.
  - While `rst`=0, every output is 0.
  - An in-flight access is abandoned. Bytes of a partial store already written stay written.

## Timing
Take T0 as the first IDLE cycle with an op and `mem_grant_i`=1.
- Byte i address appears on `mem_a_o` in cycle T0+1+i.
- Read data for byte i is on `mem_din_i` in cycle T0+2+i.
- Loads: BUSY covers T0+1..T0+1+N and DONE is cycle T0+2+N. `stall_req_o`=1 for N+2 cycles (LW: 6).
- Stores: the write pulse covers T0+1..T0+N and DONE is T0+N+1. `stall_req_o`=1 for N+1 cycles (SW: 5).
- Each cycle with `mem_grant_i`=0 in IDLE adds one stall cycle before T0.
- Non-memory ops: zero latency, combinational pass-through, never stall.

## Configuration
- `MEM_TRACE_EN` defined: on each transition out of DONE, `$display("mem %h %h", base, wb_wdata_o)` for loads and `$display("mem %h %h", base, mem_sdata_i)` for stores.
- `MEM_TRACE_EN` undefined: no display statements are compiled in. Functional behaviour is identical either way.

## Test plan
- LW @0x100, RAM bytes 11 22 33 44 → `mem_a_o` shows 0x100..0x103 in T1..T4; `wb_wdata_o`=0x44332211 in T6; `stall_req_o` high T0..T5.
- LB @0x203 with byte 0x80 → `wb_wdata_o`=0xFFFFFF80; LBU at the same address → 0x00000080.
- SH @0x10, data 0xABCD1234 → write 0x34@0x10 in T1 and 0x12@0x11 in T2; `mem_wr_o`=0 in T3; `stall_req_o` high T0..T2.
- LW with `mem_grant_i` low for 3 cycles, then high → no RAM activity during the wait; result arrives 3 cycles later than the no-wait case; `stall_req_o` held throughout.
- LH @0xFFFFFFFF, bytes 0x01@0xFFFFFFFF and 0x80@0x0 → addresses 0xFFFFFFFF then 0x00000000; `wb_wdata_o`=0xFFFF8001.
- Two cases:
  - Op 0, `wdata_i`=5, `wd_i`=3, `wreg_i`=1 → the same values appear on `wb_*` in the same cycle with `stall_req_o`=0.
  - `rst` pulled low during an SW in T2 → `mem_wr_o`=0 without waiting for a clock edge; state is IDLE after release.
